// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU run/boot sequencer.
package hack_pkg;

  localparam int HACK_WORD_W = 16;
  localparam int HACK_ROM_AW = 15;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_RST     = 4'd5,
    ST_RUN     = 4'd6,
    ST_HALT    = 4'd7,
    ST_STEP    = 4'd8
  } run_state_t;

  function automatic logic is_load_state(input run_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO);
  endfunction

  // States in which the CPU is out of reset (it keeps its PC across HALT).
  function automatic logic is_released_state(input run_state_t s);
    return (s == ST_RUN) || (s == ST_HALT) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/hack_run_ctrl_if.sv
// Host byte stream and ROM write bus of the run/boot sequencer.
interface hack_run_ctrl_if
  import hack_pkg::*;
#(
  parameter int ROM_AW = HACK_ROM_AW
) ();

  // rx: a byte moves on every rising clk edge where rx_valid & rx_ready are both 1;
  // the host holds rx_data stable while rx_valid is high and no edge has accepted it.
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   rom_we;
  logic [ROM_AW-1:0]      rom_addr;
  logic [HACK_WORD_W-1:0] rom_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, rom_we, rom_addr, rom_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, rom_we, rom_addr, rom_wdata
  );

endinterface

// File: rtl/hack_byte_packer.sv
// Assembles big-endian byte pairs into 16-bit words and strobes each finished word once.
module hack_byte_packer
  import hack_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             byte_data,
  input  logic                   hi_we,
  input  logic                   lo_we,
  output logic [HACK_WORD_W-1:0] pair,
  output logic                   word_we,
  output logic [HACK_WORD_W-1:0] word_data
);

  logic [7:0] hi_q;

  // hi_we/lo_we are already qualified by the byte handshake upstream.
  assign pair = {hi_q, byte_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q      <= '0;
      word_we   <= 1'b0;
      word_data <= '0;
    end else begin
      word_we <= lo_we;
      if (hi_we) hi_q <= byte_data;
      if (lo_we) word_data <= pair;
    end
  end

endmodule

// File: rtl/hack_run_ctrl.sv
// Run/boot sequencer for the Hack CPU: ROM load, reset release, run/halt/step clock enable.
// Optional breakpoint halt is built when HACK_RUN_CTRL_BKPT_EN is defined.
module hack_run_ctrl
  import hack_pkg::*;
#(
  parameter int ROM_AW       = HACK_ROM_AW,
  parameter int RESET_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_start,
  input  logic                   run_cmd,
  input  logic                   halt_cmd,
  input  logic                   step_cmd,
  hack_run_ctrl_if.slave         bus,
  input  logic [HACK_WORD_W-1:0] pc,
  input  logic [HACK_WORD_W-1:0] bkpt_addr,
  input  logic                   bkpt_valid,
  output logic                   cpu_reset,
  output logic                   cpu_ce,
  output logic                   halted,
  output logic                   load_err,
  output logic [31:0]            cycle_count,
  output run_state_t             state
);

  localparam logic [31:0] ROM_DEPTH = 32'd1 << ROM_AW;
  localparam logic [3:0]  RST_LAST  = 4'(RESET_CYCLES - 1);

  run_state_t             state_q, state_d;
  logic                   rx_ready_q;
  logic                   fire;
  logic                   hi_we, lo_we;
  logic                   len_fire, oversize;
  logic [HACK_WORD_W-1:0] pair;
  logic [HACK_WORD_W-1:0] words_left_q;
  logic [3:0]             rst_cnt_q;
  logic [ROM_AW-1:0]      rom_addr_q;
  logic                   word_we;
  logic [HACK_WORD_W-1:0] word_data;
  logic                   bkpt_hit;

  assign fire         = bus.rx_valid & rx_ready_q;
  assign len_fire     = (state_q == ST_LEN_LO) && fire && !load_start;
  assign oversize     = 32'(pair) > ROM_DEPTH;
  assign bus.rx_ready = rx_ready_q;
  assign bus.rom_we   = word_we;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_wdata = word_data;
  assign state        = state_q;

  hack_byte_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .byte_data (bus.rx_data),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .pair      (pair),
    .word_we   (word_we),
    .word_data (word_data)
  );

`ifdef HACK_RUN_CTRL_BKPT_EN
  // The first RUN cycle after HALT ignores the match so the breakpoint instruction executes.
  logic from_halt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) from_halt_q <= 1'b0;
    else          from_halt_q <= (state_q == ST_HALT);
  end

  assign bkpt_hit = (state_q == ST_RUN) && bkpt_valid &&
                    (pc == bkpt_addr) && !from_halt_q;
`else
  logic bkpt_unused;
  assign bkpt_unused = ^{pc, bkpt_addr, bkpt_valid};
  assign bkpt_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    cpu_ce  = 1'b0;
    if (load_start) begin
      state_d = ST_LEN_HI;
    end else begin
      case (state_q)
        ST_IDLE:    if (run_cmd) state_d = ST_RST;
        ST_LEN_HI: begin
          if (fire) begin
            hi_we   = 1'b1;
            state_d = ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (fire) state_d = (pair == '0 || oversize) ? ST_IDLE : ST_DATA_HI;
        end
        ST_DATA_HI: begin
          if (fire) begin
            hi_we   = 1'b1;
            state_d = ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (fire) begin
            lo_we   = 1'b1;
            state_d = (words_left_q == 16'd1) ? ST_IDLE : ST_DATA_HI;
          end
        end
        ST_RST:     if (rst_cnt_q == RST_LAST) state_d = ST_RUN;
        ST_RUN:     if (halt_cmd || bkpt_hit) state_d = ST_HALT;
        ST_HALT: begin
          if (halt_cmd)      state_d = ST_HALT;
          else if (step_cmd) state_d = ST_STEP;
          else if (run_cmd)  state_d = ST_RUN;
        end
        ST_STEP:    state_d = ST_HALT;
        default:    state_d = ST_IDLE;
      endcase
      cpu_ce = ((state_q == ST_RST) || (state_q == ST_RUN) || (state_q == ST_STEP))
               && !bkpt_hit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rx_ready_q   <= 1'b0;
      cpu_reset    <= 1'b1;
      halted       <= 1'b0;
      load_err     <= 1'b0;
      cycle_count  <= '0;
      rom_addr_q   <= '0;
      words_left_q <= '0;
      rst_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= is_load_state(state_d);
      cpu_reset  <= !is_released_state(state_d);
      halted     <= (state_d == ST_HALT);
      rst_cnt_q  <= (state_q == ST_RST) ? rst_cnt_q + 4'd1 : 4'd0;

      if (len_fire)   words_left_q <= pair;
      else if (lo_we) words_left_q <= words_left_q - 16'd1;

      if (load_start)              load_err <= 1'b0;
      else if (len_fire && oversize) load_err <= 1'b1;

      if (load_start)   rom_addr_q <= '0;
      else if (word_we) rom_addr_q <= rom_addr_q + 1'b1;

      if (load_start) cycle_count <= '0;
      else if (cpu_ce && !cpu_reset && cycle_count != 32'hFFFF_FFFF)
        cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Directed bench for hack_run_ctrl: ROM writes and status snapshots go through expected queues.
module tb_hack_run_ctrl;
  import hack_pkg::*;

  localparam int AW = 15;
  localparam int SW = 85;
  localparam logic [SW-1:0] M_NOPC = {{(SW-16){1'b1}}, 16'h0};
  localparam logic [SW-1:0] M_RDY  = {32'h0, 4'b0, 1'b1, 48'h0};
`ifdef HACK_RUN_CTRL_BKPT_EN
  localparam logic [SW-1:0] M_RUNPC = {32'h0, 1'b0, 1'b1, 1'b1, 2'b0, {32{1'b1}}, {16{1'b1}}};
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        load_start = 1'b0, run_cmd = 1'b0, halt_cmd = 1'b0, step_cmd = 1'b0;
  logic [15:0] bkpt_addr = 16'h0;
  logic        bkpt_valid = 1'b0;
  logic [15:0] pc_m;
  logic        cpu_reset, cpu_ce, halted, load_err;
  logic [31:0] cycle_count;
  run_state_t  dut_state_unused;

  hack_run_ctrl_if #(.ROM_AW(AW)) bus ();

  hack_run_ctrl #(.ROM_AW(AW), .RESET_CYCLES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_start  (load_start),
    .run_cmd     (run_cmd),
    .halt_cmd    (halt_cmd),
    .step_cmd    (step_cmd),
    .bus         (bus),
    .pc          (pc_m),
    .bkpt_addr   (bkpt_addr),
    .bkpt_valid  (bkpt_valid),
    .cpu_reset   (cpu_reset),
    .cpu_ce      (cpu_ce),
    .halted      (halted),
    .load_err    (load_err),
    .cycle_count (cycle_count),
    .state       (dut_state_unused)
  );

  // minimal CPU: PC clears under reset, advances on each enabled cycle
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)    pc_m <= 16'h0;
    else if (cpu_ce) pc_m <= cpu_reset ? 16'h0 : pc_m + 16'h1;
  end

  // scoreboard
  logic [AW+15:0] wr_exp_q[$];
  logic [SW-1:0]  st_exp_q[$];
  logic [SW-1:0]  st_msk_q[$];
  string          name_q[$];
  logic           chk_req = 1'b0;
  logic           fin_req = 1'b0;
  int             n_vec = 0;
  int             n_err = 0;
  logic [AW-1:0]  exp_addr = '0;
  logic [15:0]    exp_wdata = '0;

  logic [AW+15:0] mon_w;
  logic [SW-1:0]  mon_e, mon_m, mon_a;
  string          mon_n;

  always @(negedge clk) begin
    if (bus.rom_we) begin
      n_vec++;
      if (wr_exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rom_write: unexpected write addr=%h data=%h", bus.rom_addr, bus.rom_wdata);
      end else begin
        mon_w = wr_exp_q.pop_front();
        if ({bus.rom_addr, bus.rom_wdata} !== mon_w) begin
          n_err++;
          $display("FAIL rom_write: got addr=%h data=%h, expected addr=%h data=%h",
                   bus.rom_addr, bus.rom_wdata, mon_w[AW+15:16], mon_w[15:0]);
        end
      end
    end
    if (chk_req) begin
      n_vec++;
      mon_e = st_exp_q.pop_front();
      mon_m = st_msk_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = {bus.rom_we, bus.rom_addr, bus.rom_wdata, cpu_reset, cpu_ce, halted,
               load_err, bus.rx_ready, cycle_count, pc_m};
      if ((mon_a & mon_m) !== (mon_e & mon_m)) begin
        n_err++;
        $display("FAIL %s: got we/addr/wd=%h/%h/%h rst/ce/halt/err/rdy=%b cc=%0d pc=%0d, expected we/addr/wd=%h/%h/%h rst/ce/halt/err/rdy=%b cc=%0d pc=%0d",
                 mon_n, mon_a[84], mon_a[83:69], mon_a[68:53], mon_a[52:48], mon_a[47:16], mon_a[15:0],
                 mon_e[84], mon_e[83:69], mon_e[68:53], mon_e[52:48], mon_e[47:16], mon_e[15:0]);
      end
    end
    if (fin_req) begin
      n_vec++;
      if (wr_exp_q.size() != 0) begin
        n_err++;
        $display("FAIL missing_writes: got %0d pending, expected 0", wr_exp_q.size());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_raw(input string name, input logic [SW-1:0] e, input logic [SW-1:0] m);
    st_exp_q.push_back(e);
    st_msk_q.push_back(m);
    name_q.push_back(name);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic expect_st(input string name, input logic cr, input logic ce, input logic h,
                           input logic err, input logic rdy, input logic [31:0] cc);
    expect_raw(name, {1'b0, exp_addr, exp_wdata, cr, ce, h, err, rdy, cc, 16'h0}, M_NOPC);
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [15:0] d);
    wr_exp_q.push_back({a, d});
    exp_addr  = a + 1'b1;
    exp_wdata = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int k = 0; k < 16 && !acc; k++) begin
      acc = bus.rx_ready;
      tick();
    end
    bus.rx_valid = 1'b0;
    if (!acc) expect_raw("rx_accept", M_RDY, M_RDY);
  endtask

  task automatic pulse_load();
    load_start = 1'b1; tick(); load_start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic pulse_run();
    run_cmd = 1'b1; tick(); run_cmd = 1'b0;
  endtask

  task automatic pulse_halt();
    halt_cmd = 1'b1; tick(); halt_cmd = 1'b0;
  endtask

  task automatic pulse_step();
    step_cmd = 1'b1; tick(); step_cmd = 1'b0;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h0;
    #2 reset_n = 1'b0;
    expect_st("reset_values", 1, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // three-word image
    pulse_load();
    expect_st("load_len_hi", 1, 0, 0, 0, 1, 0);
    exp_wr(15'd0, 16'h1234);
    exp_wr(15'd1, 16'hABCD);
    exp_wr(15'd2, 16'h0007);
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h00); send_byte(8'h07);
    ticks(2);
    expect_st("load3_idle", 1, 0, 0, 0, 0, 0);

    // oversize length 0x8001 > 2**15
    pulse_load();
    send_byte(8'h80); send_byte(8'h01);
    tick();
    expect_st("oversize_err", 1, 0, 0, 1, 0, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    tick();
    expect_st("idle_rx_blocked", 1, 0, 0, 1, 0, 0);
    bus.rx_valid = 1'b0;

    // zero-length image clears the error
    pulse_load();
    send_byte(8'h00); send_byte(8'h00);
    tick();
    expect_st("len0_idle", 1, 0, 0, 0, 0, 0);

    // run from IDLE: two reset cycles with ce, then RUN
    pulse_run();
    expect_st("rst_cycle1", 1, 1, 0, 0, 0, 0);
    tick();
    expect_st("rst_cycle2", 1, 1, 0, 0, 0, 0);
    tick();
    expect_st("run_first", 0, 1, 0, 0, 0, 0);
    ticks(4);
    expect_st("run_count4", 0, 1, 0, 0, 0, 4);

    // halt, then three single steps
    pulse_halt();
    expect_st("halt_entry", 0, 0, 1, 0, 0, 5);
    tick();
    expect_st("halt_hold", 0, 0, 1, 0, 0, 5);
    for (int s = 0; s < 3; s++) begin
      pulse_step();
      expect_st("step_pulse", 0, 1, 0, 0, 0, 32'(5 + s));
      tick();
      expect_st("step_halted", 0, 0, 1, 0, 0, 32'(6 + s));
    end

    // resume, then same-cycle priorities
    pulse_run();
    expect_st("resume_run", 0, 1, 0, 0, 0, 8);
    halt_cmd = 1'b1; run_cmd = 1'b1; tick(); halt_cmd = 1'b0; run_cmd = 1'b0;
    expect_st("halt_beats_run", 0, 0, 1, 0, 0, 9);
    step_cmd = 1'b1; run_cmd = 1'b1; tick(); step_cmd = 1'b0; run_cmd = 1'b0;
    expect_st("step_beats_run", 0, 1, 0, 0, 0, 9);
    tick();
    expect_st("step_back_halt", 0, 0, 1, 0, 0, 10);

    // load_start while running drops ce in the same cycle
    pulse_run();
    tick();
    load_start = 1'b1;
    expect_st("load_abort_ce", 0, 0, 0, 0, 0, 11);
    tick();
    load_start = 1'b0;
    exp_addr = '0;
    expect_st("load_abort_rst", 1, 0, 0, 0, 1, 0);

    // reset in the middle of a load, after five bytes
    exp_wr(15'd0, 16'h1122);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33);
    reset_n = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    expect_st("midload_reset", 1, 0, 0, 0, 0, 0);
    ticks(2);
    reset_n = 1'b1;
    tick();
    pulse_load();
    exp_wr(15'd0, 16'hBEEF);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hBE); send_byte(8'hEF);
    ticks(2);
    expect_st("fresh_load", 1, 0, 0, 0, 0, 0);

    bkpt_addr  = 16'd5;
    bkpt_valid = 1'b1;
    pulse_run();
`ifdef HACK_RUN_CTRL_BKPT_EN
    for (int k = 0; k < 40 && !halted; k++) tick();
    expect_raw("bkpt_halt", {32'h0, 1'b0, 1'b0, 1'b1, 2'b0, 32'd5, 16'd5}, M_RUNPC);
    pulse_step();
    tick();
    expect_raw("bkpt_step", {32'h0, 1'b0, 1'b0, 1'b1, 2'b0, 32'd6, 16'd6}, M_RUNPC);
`else
    ticks(12);
    expect_st("bkpt_ignored", 0, 1, 0, 0, 0, 10);
    pulse_halt();
`endif

    ticks(3);
    fin_req = 1'b1;
    @(negedge clk);
    #1;
    fin_req = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
